// File: rtl/st_frame_tx.sv
// st_frame_tx: downstream transmit framer for the 3D self-test controller.
// Sends one frame over the TSV link toward the next layer up. The frame is
// a header, N_PAT LFSR pattern words, an XOR checksum and a trailer:
//   {13'b0, chip_id+1, 16'hBEAF}, pat[1..N_PAT], xor(hdr, pats), 32'h0000DEAD
// Handshake: a word moves on any clk edge where tx_valid && tx_ready.
//
// Optional build macro: ST_FRAME_TIMEOUT_EN. When it is defined, a stall
// watchdog aborts the frame after TIMEOUT consecutive stalled cycles and sets
// the sticky err flag. When it is not defined, stalls are unbounded and err=0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle frame request, sampled only while idle
//   chip_id[2:0]        this layer's id, captured on an accepted start
//   tx_ready            link accepts a word this cycle
//   tx_valid, tx_data   frame word output
//   busy                high from the accepted start until the frame ends
//   done                one-cycle pulse after the trailer is accepted
//   err                 sticky timeout flag
module st_frame_tx #(
  parameter int unsigned N_PAT   = 4,
  parameter logic [31:0] SEED    = 32'h1ACEB00C,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  chip_id,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, HDR, PAT, CSUM, TRL} state_t;

  localparam logic [31:0] POLY     = 32'h80200003;
  localparam logic [31:0] TRAILER  = 32'h0000DEAD;
  localparam logic [7:0]  LAST_PAT = 8'(N_PAT - 1);

  if (N_PAT < 1 || N_PAT > 255 || TIMEOUT < 1) begin : g_param_chk
    $error("st_frame_tx: N_PAT must be 1..255 and TIMEOUT >= 1");
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? POLY : 32'h0);
  endfunction

  // An all-zero Galois LFSR never leaves zero, so that seed is replaced.
  function automatic logic [31:0] lfsr_load(input logic [2:0] id);
    logic [31:0] v;
    v = SEED ^ {29'b0, id};
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  state_t      state_q, state_d;
  logic        tx_valid_d, busy_d, done_d;
  logic [31:0] tx_data_d;
  logic [31:0] lfsr_q, lfsr_d;   // equals the current pattern word while in PAT
  logic [31:0] csum_q, csum_d;   // xor of every word accepted so far
  logic [7:0]  cnt_q, cnt_d;     // pattern words accepted so far
  logic        accept;
  logic        abort;

  assign accept = tx_valid && tx_ready;

`ifdef ST_FRAME_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q;
  logic          stall;
  logic          err_q;

  assign stall = tx_valid && !tx_ready;
  // Abort on the edge that samples the TIMEOUT-th consecutive stall.
  assign abort = stall && (stall_q == SW'(TIMEOUT - 1));
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= (!stall || abort) ? '0 : stall_q + 1'b1;
      if (abort)                        err_q <= 1'b1;
      else if (state_q == IDLE && start) err_q <= 1'b0;
    end
  end
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid;
    tx_data_d  = tx_data;
    busy_d     = busy;
    done_d     = 1'b0;
    lfsr_d     = lfsr_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = HDR;
        tx_valid_d = 1'b1;
        busy_d     = 1'b1;
        tx_data_d  = {13'b0, 3'(chip_id + 3'd1), 16'hBEAF};
        lfsr_d     = lfsr_load(chip_id);
        csum_d     = 32'h0;
        cnt_d      = 8'h0;
      end
      HDR: if (accept) begin
        state_d   = PAT;
        csum_d    = csum_q ^ tx_data;
        tx_data_d = lfsr_q;
      end
      PAT: if (accept) begin
        csum_d = csum_q ^ tx_data;
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == LAST_PAT) begin
          state_d   = CSUM;
          tx_data_d = csum_q ^ tx_data;
        end else begin
          tx_data_d = lfsr_step(lfsr_q);
        end
      end
      CSUM: if (accept) begin
        state_d   = TRL;
        tx_data_d = TRAILER;
      end
      TRL: if (accept) begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        tx_data_d  = 32'h0;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      tx_data_d  = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 32'h0;
      busy     <= 1'b0;
      done     <= 1'b0;
      lfsr_q   <= 32'h0;
      csum_q   <= 32'h0;
      cnt_q    <= 8'h0;
    end else begin
      state_q  <= state_d;
      tx_valid <= tx_valid_d;
      tx_data  <= tx_data_d;
      busy     <= busy_d;
      done     <= done_d;
      lfsr_q   <= lfsr_d;
      csum_q   <= csum_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: doc/st_frame_tx.md
Name: st_frame_tx

Overview:
- Downstream transmit framer for the 3D self-test controller.
- Once the controller has obtained its chip_id and enters its transmit phase, this block builds the test frame. It drives the frame word by word over the vertical (TSV) link toward the next layer up.
- The frame contains a header carrying the next layer's id, LFSR pattern words, an XOR checksum and a trailer. The receiving layer's self-test controller detects the 0xBEAF header and checks the pattern.

Parameters:
- N_PAT, 4, number of pattern words per frame (1..255).
- SEED, 32'h1ACEB00C, LFSR base seed.
- TIMEOUT, 1023, stall-cycle limit; used only with ST_FRAME_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to send a frame; sampled only in IDLE.
- chip_id  input  3  this layer's id; captured on accepted start.
- tx_ready  input  1  link can accept a word this cycle.
- tx_valid  output  1  tx_data holds a valid frame word.
- tx_data  output  32  frame word.
- busy  output  1  high from accepted start until the frame ends.
- done  output  1  one-cycle pulse after the trailer is accepted.
- err  output  1  sticky timeout flag (0 when the feature is compiled out).

Behaviour:
- Reset: all registers are asynchronously reset.
  - tx_valid=0, tx_data=0, busy=0, done=0, err=0, state=IDLE.
- Transfer rule: a word is accepted when tx_valid && tx_ready at a rising clk edge.
  - While tx_valid=1 && tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without acceptance, except on timeout abort or reset.
- States and transitions:
  - IDLE → HDR on start. busy=1 and tx_valid=1 take effect the next cycle, so the first word appears 1 cycle after start.
  - HDR → PAT on accept.
  - PAT → CSUM when the N_PAT-th pattern word is accepted.
  - CSUM → TRL on accept.
  - TRL → IDLE on accept. On that edge: done=1 for one cycle, busy=0, tx_valid=0.
- Header word: {13'b0, id_next, 16'hBEAF}, where id_next = captured chip_id + 1 mod 8 (so 7 wraps to 0).
- LFSR:
  - Load value = SEED ^ {29'b0, chip_id}. If the load value is 0, load 32'h00000001 instead.
  - Pattern word 1 is the load value.
  - The LFSR advances on each accepted pattern word using a Galois right shift: next = (l>>1) ^ (l[0] ? 32'h80200003 : 0).
- Checksum word: XOR of the header and all N_PAT pattern words. The accumulator updates on each accept.
- Trailer word: 32'h0000DEAD.
- Frame length: N_PAT+3 words. With tx_ready held high, the minimum duration is N_PAT+3 cycles plus the 1-cycle start latency.
- Boundary conditions:
  - start while busy is ignored, including start in the same cycle as the trailer accept.
  - chip_id changes after capture have no effect on the frame in flight.
  - Reset mid-frame aborts immediately. No done pulse is produced and no partial state is kept.
  - done and err are never both asserted for the same frame.

Optional Feature:
- Macro: ST_FRAME_TIMEOUT_EN.
- With the macro defined:
  - A stall counter counts consecutive cycles with tx_valid=1 && tx_ready=0. It clears on each accept and on return to IDLE.
  - When the count reaches TIMEOUT, the block aborts: next cycle tx_valid=0, busy=0, state=IDLE, and err=1.
  - No done pulse is produced for an aborted frame.
  - err stays set until reset or the next accepted start.
- Without the macro: no counter logic is built, err is tied to 0, and stalls are unbounded.

Test Plan:
- Reset, chip_id=0, defaults, tx_ready=1, one start pulse → exact word sequence 0x0001BEAF, 0x1ACEB00C, 0x0D675806, 0x06B3AC03, 0x8379D602, 0x92622CA4, 0x0000DEAD on 7 consecutive cycles; done pulses once; busy is high for exactly 7 cycles.
- chip_id=7, start → header 0x0000BEAF (id wrap); first pattern word 0x1ACEB00B.
- Same frame as the first scenario with tx_ready randomly deasserted → tx_data stable throughout every stall; received word sequence identical to the first scenario.
- start pulsed while busy, and again on the trailer-accept cycle → no second frame; busy goes 0 after the trailer; done pulses once.
- rst_n asserted during the PAT state → outputs go to their reset values immediately; no done pulse; a following start produces a clean frame identical to the first scenario.
- ST_FRAME_TIMEOUT_EN with TIMEOUT=8: hold tx_ready=0 after the header is presented → after 8 stall cycles tx_valid=0, busy=0, err=1, no done pulse; the next start clears err.
